sram_axi_bridge: RTL and testbench
==================================

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL have port clk, in, 1: sole clock, rising edge.
REQ-003 SHALL have port reset, in, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports inst_sram_req/wr, in, 1 each: instruction request and write flag.
REQ-005 SHALL have ports inst_sram_size, in, 2, and inst_sram_wstrb, in, 4: instruction request size and strobe.
REQ-006 SHALL have ports inst_sram_addr/wdata, in, 32 each: instruction address and write data.
REQ-007 SHALL have ports inst_sram_addr_ok/data_ok, out, 1 each, and inst_sram_rdata, out, 32: instruction handshake and read data.
REQ-008 SHALL have a data_sram_* port set identical to REQ-004..007.
REQ-009 SHALL have AXI read-address outputs arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1, and input arready 1.
REQ-010 SHALL have AXI read-data inputs rid 4, rdata 32, rresp 2, rlast 1, rvalid 1, and output rready 1.
REQ-011 SHALL have AXI write-address outputs awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot and awvalid with ar* widths, and input awready 1.
REQ-012 SHALL have AXI write-data outputs wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1, and input wready 1.
REQ-013 SHALL have AXI write-response inputs bid 4, bresp 2, bvalid 1, and output bready 1.

Function
REQ-014 SHALL tie off arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, awid=wid=4'd1, wlast=1; rresp, bresp and bid SHALL be ignored.
REQ-015 SHALL drive arsize/awsize as {1'b0, size} from the accepted request.
REQ-016 SHALL assert addr_ok combinationally in the cycle the request is accepted: req=1 and the acceptance condition holds.
REQ-017 SHALL accept a read when the AR register is empty and no read with the same ID is outstanding; data reads additionally require no write outstanding.
REQ-018 SHALL give data priority over inst when both are acceptable in one cycle; the inst addr_ok SHALL then be 0.
REQ-019 SHALL assert arvalid in the cycle after acceptance, holding araddr/arid/arsize stable until arvalid&arready; arid SHALL be 0 for inst and 1 for data.
REQ-020 SHALL allow at most two reads outstanding, one per ID; rready SHALL be 1 while any read is outstanding.
REQ-021 SHALL, on rvalid&rready, register rdata and pulse the matching data_ok (rid 0 -> inst, 1 -> data) for exactly one cycle in the next cycle, with rdata valid while that data_ok=1.
REQ-022 SHALL accept a data write when no write and no data read is outstanding.
REQ-023 SHALL raise awvalid and wvalid together in the cycle after write acceptance, dropping each independently on its own handshake.
REQ-024 SHALL assert bready once both the AW and W handshakes have completed, until bvalid.
REQ-025 SHALL pulse data_sram_data_ok for one cycle in the cycle after bvalid&bready.
REQ-026 SHALL never accept an inst request with inst_sram_wr=1; its addr_ok SHALL stay 0.
REQ-027 SHALL handle a simultaneous rvalid for one ID and bvalid in one cycle, producing both data_ok pulses in the correct order without loss (inst and data in the same cycle where IDs differ).
REQ-028 SHALL treat data-read-after-write ordering as guaranteed, because a data read stalls until the outstanding write's B response.

Reset
REQ-029 SHALL reset asynchronously on reset=1: all valid/ready outputs, addr_ok, data_ok and outstanding flags to 0; registered addresses and data to 0.
REQ-030 SHALL drop any in-flight transaction on reset mid-operation, with no data_ok issued afterwards for it.

Structure
REQ-031 SHALL take from the shared package (width.h): AXI width macros (A_ID_WID, A_LEN_WID, A_SIZE_WID, A_BURST_WID, A_LOCK_WID, A_CACHE_WID, A_PROT_WID, A_STRB_WID), the ID constants INST_ID=0 and DATA_ID=1, and the fixed burst value.
REQ-032 SHALL place the write path (AW/W/B tracking) in one sub-module sram_axi_wr_ch; the read arbiter and R demux SHALL stay in the top.

Verification
REQ-033 SHALL cover: inst read 0x1c000000 with arready=1 -> addr_ok same cycle, arvalid next cycle with arid=0; rvalid with rdata=0x02800c0c, rid=0 -> inst data_ok and rdata=0x02800c0c one cycle later.
REQ-034 SHALL cover: inst and data reads in the same cycle -> only data addr_ok=1; AR sequence arid 1 then 0; R returned in order 0 then 1 -> correct data_ok per side.
REQ-035 SHALL cover: data write addr 0x1c001000, wdata 0xdeadbeef, wstrb 4'hf, with wready 3 cycles after awready -> bready only after W completes; data_ok 1 cycle after bvalid.
REQ-036 SHALL cover: data read issued while a write is outstanding -> addr_ok=0 until the cycle after B; the read then returns the written value.
REQ-037 SHALL cover: arready held 0 for 5 cycles -> araddr/arid stable and further reads refused.
REQ-038 SHALL cover: reset asserted during an outstanding read -> all outputs 0 and no data_ok after reset release.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// Shared widths, IDs and types for the SRAM-to-AXI bridge.
package sram_axi_bridge_pkg;

  localparam int A_ID_WID    = 4;
  localparam int A_LEN_WID   = 8;
  localparam int A_SIZE_WID  = 3;
  localparam int A_BURST_WID = 2;
  localparam int A_LOCK_WID  = 2;
  localparam int A_CACHE_WID = 4;
  localparam int A_PROT_WID  = 3;
  localparam int A_STRB_WID  = 4;

  localparam logic [A_ID_WID-1:0]    INST_ID    = 4'd0;
  localparam logic [A_ID_WID-1:0]    DATA_ID    = 4'd1;
  localparam logic [A_BURST_WID-1:0] BURST_INCR = 2'b01;
  localparam logic [A_LEN_WID-1:0]   LEN_SINGLE = '0;

  // Bit positions in the per-ID read-outstanding vector.
  localparam int INST_SLOT = 0;
  localparam int DATA_SLOT = 1;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SEND,
    WR_RESP
  } wr_state_e;

  // SRAM size codes map straight onto AXI size codes with a zero top bit.
  function automatic logic [A_SIZE_WID-1:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_wr_ch.sv
// Write path: holds one data write, drives AW and W, then waits for B.
module sram_axi_wr_ch
  import sram_axi_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [A_STRB_WID-1:0] req_wstrb,
  input  logic [1:0]            req_size,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           awaddr,
  output logic [A_SIZE_WID-1:0] awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [A_STRB_WID-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  wr_state_e             state_q, state_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic                  done_q, done_d;
  logic [31:0]           awaddr_q, awaddr_d;
  logic [A_SIZE_WID-1:0] awsize_q, awsize_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [A_STRB_WID-1:0] wstrb_q, wstrb_d;

  // Next-state: AW and W retire independently; B is awaited only once both are gone.
  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    done_d    = 1'b0;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (state_q)
      WR_IDLE: begin
        if (accept) begin
          state_d   = WR_SEND;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          awaddr_d  = req_addr;
          awsize_d  = axi_size(req_size);
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
        end
      end
      WR_SEND: begin
        if (aw_pend_q && awready) aw_pend_d = 1'b0;
        if (w_pend_q && wready) w_pend_d = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d = WR_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // State and captured write registers; reset drops any write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WR_IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      done_q    <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      done_q    <= done_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign busy    = (state_q != WR_IDLE);
  assign done    = done_q;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = aw_pend_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = w_pend_q;
  assign bready  = (state_q == WR_RESP);

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges an instruction and a data SRAM-like port onto one AXI master.
// Reads are arbitrated here (data first) and returned by ID; writes live in sram_axi_wr_ch.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   inst_sram_req,
  input  logic                   inst_sram_wr,
  input  logic [1:0]             inst_sram_size,
  input  logic [3:0]             inst_sram_wstrb,
  input  logic [31:0]            inst_sram_addr,
  input  logic [31:0]            inst_sram_wdata,
  output logic                   inst_sram_addr_ok,
  output logic                   inst_sram_data_ok,
  output logic [31:0]            inst_sram_rdata,

  input  logic                   data_sram_req,
  input  logic                   data_sram_wr,
  input  logic [1:0]             data_sram_size,
  input  logic [3:0]             data_sram_wstrb,
  input  logic [31:0]            data_sram_addr,
  input  logic [31:0]            data_sram_wdata,
  output logic                   data_sram_addr_ok,
  output logic                   data_sram_data_ok,
  output logic [31:0]            data_sram_rdata,

  output logic [A_ID_WID-1:0]    arid,
  output logic [31:0]            araddr,
  output logic [A_LEN_WID-1:0]   arlen,
  output logic [A_SIZE_WID-1:0]  arsize,
  output logic [A_BURST_WID-1:0] arburst,
  output logic [A_LOCK_WID-1:0]  arlock,
  output logic [A_CACHE_WID-1:0] arcache,
  output logic [A_PROT_WID-1:0]  arprot,
  output logic                   arvalid,
  input  logic                   arready,

  input  logic [A_ID_WID-1:0]    rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,

  output logic [A_ID_WID-1:0]    awid,
  output logic [31:0]            awaddr,
  output logic [A_LEN_WID-1:0]   awlen,
  output logic [A_SIZE_WID-1:0]  awsize,
  output logic [A_BURST_WID-1:0] awburst,
  output logic [A_LOCK_WID-1:0]  awlock,
  output logic [A_CACHE_WID-1:0] awcache,
  output logic [A_PROT_WID-1:0]  awprot,
  output logic                   awvalid,
  input  logic                   awready,

  output logic [A_ID_WID-1:0]    wid,
  output logic [31:0]            wdata,
  output logic [A_STRB_WID-1:0]  wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,

  input  logic [A_ID_WID-1:0]    bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  logic [1:0]            rd_out_q, rd_out_d;
  logic                  ar_valid_q, ar_valid_d;
  logic [31:0]           araddr_q, araddr_d;
  logic [A_ID_WID-1:0]   arid_q, arid_d;
  logic [A_SIZE_WID-1:0] arsize_q, arsize_d;
  logic                  inst_ok_q, inst_ok_d;
  logic                  data_rd_ok_q, data_rd_ok_d;
  logic [31:0]           inst_rdata_q, inst_rdata_d;
  logic [31:0]           data_rdata_q, data_rdata_d;

  logic data_rd_acc, data_wr_acc, inst_rd_acc;
  logic wr_busy, wr_done;
  logic r_fire, r_inst, r_data;
  logic unused_ok;

  // Acceptance: data reads also wait out any write so read-after-write is ordered,
  // and data wins over inst whenever it is accepted.
  always_comb begin
    data_rd_acc = data_sram_req && !data_sram_wr && !reset && !ar_valid_q &&
                  !rd_out_q[DATA_SLOT] && !wr_busy;
    data_wr_acc = data_sram_req && data_sram_wr && !reset && !wr_busy &&
                  !rd_out_q[DATA_SLOT];
    inst_rd_acc = inst_sram_req && !inst_sram_wr && !reset && !ar_valid_q &&
                  !rd_out_q[INST_SLOT] && !data_rd_acc && !data_wr_acc;
  end

  // AR register load/drain and per-ID outstanding tracking.
  always_comb begin
    ar_valid_d = ar_valid_q;
    araddr_d   = araddr_q;
    arid_d     = arid_q;
    arsize_d   = arsize_q;
    rd_out_d   = rd_out_q;
    if (ar_valid_q && arready) ar_valid_d = 1'b0;
    if (data_rd_acc) begin
      ar_valid_d          = 1'b1;
      araddr_d            = data_sram_addr;
      arid_d              = DATA_ID;
      arsize_d            = axi_size(data_sram_size);
      rd_out_d[DATA_SLOT] = 1'b1;
    end else if (inst_rd_acc) begin
      ar_valid_d          = 1'b1;
      araddr_d            = inst_sram_addr;
      arid_d              = INST_ID;
      arsize_d            = axi_size(inst_sram_size);
      rd_out_d[INST_SLOT] = 1'b1;
    end
    if (r_inst) rd_out_d[INST_SLOT] = 1'b0;
    if (r_data) rd_out_d[DATA_SLOT] = 1'b0;
  end

  // R demux: route returned data by ID into a one-cycle data_ok and held rdata.
  always_comb begin
    r_fire       = rvalid && rready;
    r_inst       = r_fire && (rid == INST_ID) && rd_out_q[INST_SLOT];
    r_data       = r_fire && (rid == DATA_ID) && rd_out_q[DATA_SLOT];
    inst_ok_d    = r_inst;
    data_rd_ok_d = r_data;
    inst_rdata_d = r_inst ? rdata : inst_rdata_q;
    data_rdata_d = r_data ? rdata : data_rdata_q;
  end

  // Read-side registers; reset forgets every outstanding read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_out_q     <= '0;
      ar_valid_q   <= 1'b0;
      araddr_q     <= '0;
      arid_q       <= '0;
      arsize_q     <= '0;
      inst_ok_q    <= 1'b0;
      data_rd_ok_q <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      rd_out_q     <= rd_out_d;
      ar_valid_q   <= ar_valid_d;
      araddr_q     <= araddr_d;
      arid_q       <= arid_d;
      arsize_q     <= arsize_d;
      inst_ok_q    <= inst_ok_d;
      data_rd_ok_q <= data_rd_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  sram_axi_wr_ch u_wr_ch (
    .clk       (clk),
    .reset     (reset),
    .accept    (data_wr_acc),
    .req_addr  (data_sram_addr),
    .req_wdata (data_sram_wdata),
    .req_wstrb (data_sram_wstrb),
    .req_size  (data_sram_size),
    .busy      (wr_busy),
    .done      (wr_done),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready)
  );

  assign inst_sram_addr_ok = inst_rd_acc;
  assign inst_sram_data_ok = inst_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  assign data_sram_data_ok = data_rd_ok_q || wr_done;
  assign data_sram_rdata   = data_rdata_q;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = arsize_q;
  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = ar_valid_q;
  assign rready  = |rd_out_q;

  assign awid    = DATA_ID;
  assign awlen   = LEN_SINGLE;
  assign awburst = BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;

  // Response codes, write IDs, rlast and the inst write fields carry no information here.
  assign unused_ok = ^{rresp, bresp, bid, rlast, inst_sram_wstrb, inst_sram_wdata};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with queue-based scoreboards for R, B, AR, AW and W.
module tb_sram_axi_bridge;

  logic        clk;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    bit          isWrite;
    logic [31:0] rdata;
  } dataExp_t;

  logic [31:0] instQ[$];
  dataExp_t    dataQ[$];
  logic [38:0] arQ[$];
  logic [31:0] awQ[$];
  logic [35:0] wQ[$];
  logic [31:0] slaveMem;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic iReq, input logic iWr, input logic [31:0] iAddr,
                               input logic dReq, input logic dWr, input logic [31:0] dAddr,
                               input logic [31:0] dWdata);
    inst_sram_req   = iReq;
    inst_sram_wr    = iWr;
    inst_sram_addr  = iAddr;
    inst_sram_size  = 2'd2;
    inst_sram_wstrb = 4'h0;
    inst_sram_wdata = 32'h0;
    data_sram_req   = dReq;
    data_sram_wr    = dWr;
    data_sram_addr  = dAddr;
    data_sram_wdata = dWdata;
    data_sram_size  = 2'd2;
    data_sram_wstrb = 4'hf;
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a response or handshake.
  always @(negedge clk) begin
    logic [31:0] iExp;
    dataExp_t    dExp;
    logic [38:0] arExp;
    logic [31:0] awExp;
    logic [35:0] wExp;
    if (!reset) begin
      if (inst_sram_data_ok) begin
        if (instQ.size() == 0) checkBit("inst_data_ok_spurious", inst_sram_data_ok, 1'b0);
        else begin
          iExp = instQ.pop_front();
          checkOutput("sb_inst_rdata", 64'(inst_sram_rdata), 64'(iExp));
        end
      end
      if (data_sram_data_ok) begin
        if (dataQ.size() == 0) checkBit("data_data_ok_spurious", data_sram_data_ok, 1'b0);
        else begin
          dExp = dataQ.pop_front();
          if (!dExp.isWrite) checkOutput("sb_data_rdata", 64'(data_sram_rdata), 64'(dExp.rdata));
        end
      end
      if (arvalid && arready) begin
        if (arQ.size() == 0) checkBit("ar_spurious", arvalid, 1'b0);
        else begin
          arExp = arQ.pop_front();
          checkOutput("sb_ar", 64'({arid, araddr, arsize}), 64'(arExp));
        end
      end
      if (awvalid && awready) begin
        if (awQ.size() == 0) checkBit("aw_spurious", awvalid, 1'b0);
        else begin
          awExp = awQ.pop_front();
          checkOutput("sb_awaddr", 64'(awaddr), 64'(awExp));
        end
      end
      if (wvalid && wready) begin
        if (wQ.size() == 0) checkBit("w_spurious", wvalid, 1'b0);
        else begin
          wExp = wQ.pop_front();
          checkOutput("sb_w", 64'({wstrb, wdata}), 64'(wExp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    arready = 1'b0; rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'b00; bvalid = 1'b0;
    slaveMem = 32'h0;

    // Reset state
    midCycle();
    checkBit("rst_arvalid", arvalid, 1'b0);
    checkBit("rst_awvalid", awvalid, 1'b0);
    checkBit("rst_wvalid", wvalid, 1'b0);
    checkBit("rst_rready", rready, 1'b0);
    checkBit("rst_bready", bready, 1'b0);
    checkBit("rst_inst_data_ok", inst_sram_data_ok, 1'b0);
    checkBit("rst_data_data_ok", data_sram_data_ok, 1'b0);
    nextCycle();
    reset = 1'b0;

    // Single inst read
    nextCycle();
    arready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h1c000000, 1'b0, 1'b0, 32'h0, 32'h0);
    arQ.push_back({4'd0, 32'h1c000000, 3'd2});
    midCycle();
    checkBit("t1_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    checkBit("t1_arvalid_early", arvalid, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkBit("t1_arvalid", arvalid, 1'b1);
    checkOutput("t1_arid", 64'(arid), 64'd0);
    nextCycle();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800c0c;
    instQ.push_back(32'h02800c0c);
    midCycle();
    checkBit("t1_rready", rready, 1'b1);
    checkBit("t1_data_ok_early", inst_sram_data_ok, 1'b0);
    nextCycle();
    rvalid = 1'b0;
    midCycle();
    checkBit("t1_data_ok", inst_sram_data_ok, 1'b1);
    checkOutput("t1_rdata", 64'(inst_sram_rdata), 64'h02800c0c);
    nextCycle();
    midCycle();
    checkBit("t1_data_ok_pulse", inst_sram_data_ok, 1'b0);
    checkBit("t1_rready_idle", rready, 1'b0);

    // Simultaneous inst and data reads
    nextCycle();
    arready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h1c000100, 1'b1, 1'b0, 32'h1c002000, 32'h0);
    arQ.push_back({4'd1, 32'h1c002000, 3'd2});
    midCycle();
    checkBit("t2_data_addr_ok", data_sram_addr_ok, 1'b1);
    checkBit("t2_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h1c000100, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkBit("t2_inst_blocked", inst_sram_addr_ok, 1'b0);
    checkOutput("t2_arid_first", 64'(arid), 64'd1);
    nextCycle();
    arQ.push_back({4'd0, 32'h1c000100, 3'd2});
    midCycle();
    checkBit("t2_inst_addr_ok_late", inst_sram_addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkOutput("t2_arid_second", 64'(arid), 64'd0);
    nextCycle();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h11111111;
    instQ.push_back(32'h11111111);
    nextCycle();
    rid = 4'd1; rdata = 32'h22222222;
    dataQ.push_back('{isWrite: 1'b0, rdata: 32'h22222222});
    midCycle();
    checkBit("t2_inst_ok", inst_sram_data_ok, 1'b1);
    checkBit("t2_data_ok_early", data_sram_data_ok, 1'b0);
    nextCycle();
    rvalid = 1'b0;
    midCycle();
    checkBit("t2_data_ok", data_sram_data_ok, 1'b1);
    checkBit("t2_inst_ok_pulse", inst_sram_data_ok, 1'b0);

    // Data write with W delayed three cycles behind AW
    nextCycle();
    awready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c001000, 32'hdeadbeef);
    awQ.push_back(32'h1c001000);
    wQ.push_back({4'hf, 32'hdeadbeef});
    midCycle();
    checkBit("t3_addr_ok", data_sram_addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkBit("t3_awvalid", awvalid, 1'b1);
    checkBit("t3_wvalid", wvalid, 1'b1);
    nextCycle();
    awready = 1'b0;
    midCycle();
    checkBit("t3_awvalid_drop", awvalid, 1'b0);
    checkBit("t3_wvalid_hold", wvalid, 1'b1);
    checkBit("t3_bready_c", bready, 1'b0);
    nextCycle();
    midCycle();
    checkBit("t3_bready_d", bready, 1'b0);
    nextCycle();
    wready = 1'b1;
    midCycle();
    checkBit("t3_bready_e", bready, 1'b0);
    nextCycle();
    wready = 1'b0;
    midCycle();
    checkBit("t3_wvalid_drop", wvalid, 1'b0);
    checkBit("t3_bready", bready, 1'b1);
    checkBit("t3_data_ok_early", data_sram_data_ok, 1'b0);
    nextCycle();
    bvalid = 1'b1;
    dataQ.push_back('{isWrite: 1'b1, rdata: 32'h0});
    nextCycle();
    bvalid = 1'b0;
    midCycle();
    checkBit("t3_data_ok", data_sram_data_ok, 1'b1);
    checkBit("t3_bready_drop", bready, 1'b0);
    nextCycle();
    midCycle();
    checkBit("t3_data_ok_pulse", data_sram_data_ok, 1'b0);

    // Data read stalled behind an outstanding write
    nextCycle();
    awready = 1'b1; wready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c003000, 32'hcafef00d);
    awQ.push_back(32'h1c003000);
    wQ.push_back({4'hf, 32'hcafef00d});
    slaveMem = 32'hcafef00d;
    midCycle();
    checkBit("t4_wr_addr_ok", data_sram_addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1c003000, 32'h0);
    midCycle();
    checkBit("t4_rd_stall_b", data_sram_addr_ok, 1'b0);
    nextCycle();
    awready = 1'b0; wready = 1'b0;
    midCycle();
    checkBit("t4_rd_stall_c", data_sram_addr_ok, 1'b0);
    nextCycle();
    bvalid = 1'b1;
    dataQ.push_back('{isWrite: 1'b1, rdata: 32'h0});
    midCycle();
    checkBit("t4_rd_stall_d", data_sram_addr_ok, 1'b0);
    nextCycle();
    bvalid = 1'b0; arready = 1'b1;
    arQ.push_back({4'd1, 32'h1c003000, 3'd2});
    midCycle();
    checkBit("t4_rd_addr_ok", data_sram_addr_ok, 1'b1);
    checkBit("t4_wr_data_ok", data_sram_data_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    dataQ.push_back('{isWrite: 1'b0, rdata: 32'hcafef00d});
    nextCycle();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = slaveMem;
    nextCycle();
    rvalid = 1'b0;
    midCycle();
    checkBit("t4_rd_data_ok", data_sram_data_ok, 1'b1);
    checkOutput("t4_rd_rdata", 64'(data_sram_rdata), 64'hcafef00d);

    // Simultaneous R (inst) and B (data) responses
    nextCycle();
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h1c000300, 1'b1, 1'b1, 32'h1c005000, 32'h12345678);
    awQ.push_back(32'h1c005000);
    wQ.push_back({4'hf, 32'h12345678});
    midCycle();
    checkBit("t7_data_addr_ok", data_sram_addr_ok, 1'b1);
    checkBit("t7_inst_addr_ok_blocked", inst_sram_addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h1c000300, 1'b0, 1'b0, 32'h0, 32'h0);
    arQ.push_back({4'd0, 32'h1c000300, 3'd2});
    midCycle();
    checkBit("t7_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkBit("t7_bready", bready, 1'b1);
    nextCycle();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h55555555; bvalid = 1'b1;
    instQ.push_back(32'h55555555);
    dataQ.push_back('{isWrite: 1'b1, rdata: 32'h0});
    nextCycle();
    rvalid = 1'b0; bvalid = 1'b0;
    midCycle();
    checkBit("t7_inst_ok", inst_sram_data_ok, 1'b1);
    checkBit("t7_data_ok", data_sram_data_ok, 1'b1);
    checkOutput("t7_inst_rdata", 64'(inst_sram_rdata), 64'h55555555);

    // arready held low: AR stays put and further reads are refused
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h1c000200, 1'b0, 1'b0, 32'h0, 32'h0);
    arQ.push_back({4'd0, 32'h1c000200, 3'd2});
    midCycle();
    checkBit("t5_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1c004000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      midCycle();
      checkBit("t5_arvalid_hold", arvalid, 1'b1);
      checkOutput("t5_araddr_hold", 64'(araddr), 64'h1c000200);
      checkOutput("t5_arid_hold", 64'(arid), 64'd0);
      checkBit("t5_data_refused", data_sram_addr_ok, 1'b0);
      nextCycle();
    end
    arready = 1'b1;
    midCycle();
    checkBit("t5_data_refused_last", data_sram_addr_ok, 1'b0);
    nextCycle();
    arQ.push_back({4'd1, 32'h1c004000, 3'd2});
    midCycle();
    checkBit("t5_data_addr_ok", data_sram_addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkOutput("t5_arid_data", 64'(arid), 64'd1);
    nextCycle();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h44444444;
    dataQ.push_back('{isWrite: 1'b0, rdata: 32'h44444444});
    nextCycle();
    rid = 4'd0; rdata = 32'h33333333;
    instQ.push_back(32'h33333333);
    midCycle();
    checkBit("t5_data_ok", data_sram_data_ok, 1'b1);
    nextCycle();
    rvalid = 1'b0;
    midCycle();
    checkBit("t5_inst_ok", inst_sram_data_ok, 1'b1);

    // Inst write requests are never accepted
    nextCycle();
    arready = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h1c000500, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkBit("t8_inst_wr_refused", inst_sram_addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkBit("t8_no_arvalid", arvalid, 1'b0);
    checkBit("t8_no_awvalid", awvalid, 1'b0);

    // Reset during an outstanding read
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h1c000400, 1'b0, 1'b0, 32'h0, 32'h0);
    arQ.push_back({4'd0, 32'h1c000400, 3'd2});
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    midCycle();
    checkBit("t6_arvalid", arvalid, 1'b1);
    nextCycle();
    arready = 1'b0;
    reset = 1'b1;
    midCycle();
    checkBit("t6_rst_arvalid", arvalid, 1'b0);
    checkBit("t6_rst_rready", rready, 1'b0);
    checkBit("t6_rst_inst_ok", inst_sram_data_ok, 1'b0);
    checkBit("t6_rst_data_ok", data_sram_data_ok, 1'b0);
    checkOutput("t6_rst_inst_rdata", 64'(inst_sram_rdata), 64'd0);
    checkOutput("t6_rst_data_rdata", 64'(data_sram_rdata), 64'd0);
    nextCycle();
    reset = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h66666666;
    midCycle();
    checkBit("t6_post_rready", rready, 1'b0);
    checkBit("t6_post_inst_ok_a", inst_sram_data_ok, 1'b0);
    nextCycle();
    midCycle();
    checkBit("t6_post_inst_ok_b", inst_sram_data_ok, 1'b0);
    nextCycle();
    rvalid = 1'b0;
    midCycle();
    checkBit("t6_post_inst_ok_c", inst_sram_data_ok, 1'b0);

    // Every expected event must have been consumed
    nextCycle();
    nextCycle();
    checkOutput("instQ_drained", 64'(instQ.size()), 64'd0);
    checkOutput("dataQ_drained", 64'(dataQ.size()), 64'd0);
    checkOutput("arQ_drained", 64'(arQ.size()), 64'd0);
    checkOutput("awQ_drained", 64'(awQ.size()), 64'd0);
    checkOutput("wQ_drained", 64'(wQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
